// File: rtl/seq_cpu_pkg.sv
//------------------------------------------------------------------------------
// seq_cpu_pkg
//   Shared constants for the multi-cycle CPU: opcode width, opcode values
//   and the FSM state encoding.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_LDI = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b100;
  localparam logic [OPC_W-1:0] OP_NOT = 3'b101;
  localparam logic [OPC_W-1:0] OP_INC = 3'b110;
  localparam logic [OPC_W-1:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_cpu_alu.sv
//------------------------------------------------------------------------------
// seq_cpu_alu
//   Combinational ALU for seq_cpu.
//   Ports: opcode (3b), a/b (register operands), field (immediate),
//          y (result), carry (carry-out or borrow), zero (y == 0).
//   Build option: SEQ_CPU_SAT_EN makes ADD/INC saturate at all-ones and
//   SUB/DEC clamp at zero; carry still reports the raw overflow/borrow.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_cpu_alu
  import seq_cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] field,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;

  // INC/DEC share the adder/subtractor with a constant 1 on the right side.
  assign rhs     = (opcode == OP_INC || opcode == OP_DEC) ? ONE : b;
  assign add_res = {1'b0, a} + {1'b0, rhs};
  // The extra MSB of a zero-extended subtraction is the borrow (a < rhs).
  assign sub_res = {1'b0, a} - {1'b0, rhs};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (opcode)
      OP_LDI: y = field;
      OP_ADD, OP_INC: begin
        carry = add_res[WIDTH];
        y     = add_res[WIDTH-1:0];
`ifdef SEQ_CPU_SAT_EN
        if (add_res[WIDTH]) y = '1;
`endif
      end
      OP_SUB, OP_DEC: begin
        carry = sub_res[WIDTH];
        y     = sub_res[WIDTH-1:0];
`ifdef SEQ_CPU_SAT_EN
        if (sub_res[WIDTH]) y = '0;
`endif
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_NOT: y = ~a;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

`default_nettype wire

// File: rtl/seq_cpu.sv
//------------------------------------------------------------------------------
// seq_cpu
//   Multi-cycle CPU with an internal register file and valid/ready handshakes.
//   Instruction = {opcode[2:0], rd, rs1, field[WIDTH-1:0]}; rs2 = field[RA-1:0].
//   Ports: clk, rst (async, active high),
//          in_valid/in_ready/instruction  - instruction input handshake,
//          out_valid/out_ready/result/carry/zero - result output handshake.
//   Build option: SEQ_CPU_SAT_EN (saturating arithmetic, see seq_cpu_alu).
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_cpu
  import seq_cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [OPC_W+2*$clog2(NREGS)+WIDTH-1:0]    instruction,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [WIDTH-1:0]                          result,
  output logic                                      carry,
  output logic                                      zero
);

  localparam int RA      = $clog2(NREGS);
  localparam int INSTR_W = OPC_W + 2*RA + WIDTH;

  state_t state;
  state_t next_state;

  logic [INSTR_W-1:0] instr_q;
  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               rdy;

  logic [OPC_W-1:0]   opcode;
  logic [RA-1:0]      rd;
  logic [RA-1:0]      rs1;
  logic [RA-1:0]      rs2;
  logic [WIDTH-1:0]   field;

  logic [WIDTH-1:0]   alu_y;
  logic               alu_carry;
  logic               alu_zero;

  logic               accept;

  assign opcode = instr_q[INSTR_W-1 -: OPC_W];
  assign rd     = instr_q[2*RA+WIDTH-1 -: RA];
  assign rs1    = instr_q[RA+WIDTH-1 -: RA];
  assign field  = instr_q[WIDTH-1:0];
  assign rs2    = field[RA-1:0];

  assign in_ready = rdy;
  assign accept   = in_valid && rdy;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    case (state)
      IDLE: if (accept) next_state = READ;
      READ: next_state = EXEC;
      EXEC: next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // in_ready is registered so it stays low until the first edge after reset
  // release; afterwards it tracks "state is IDLE".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy <= 1'b0;
    else     rdy <= (next_state == IDLE);
  end

  // Datapath: instruction latch, operand latch, register file, result regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && accept) instr_q <= instruction;
      // Operands are captured before the write in EXEC, so rd==rs is safe.
      if (state == READ) begin
        op_a <= regs[rs1];
        op_b <= regs[rs2];
      end
      if (state == EXEC) begin
        regs[rd] <= alu_y;
        result   <= alu_y;
        carry    <= alu_carry;
        zero     <= alu_zero;
      end
    end
  end

  seq_cpu_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .opcode (opcode),
    .a      (op_a),
    .b      (op_b),
    .field  (field),
    .y      (alu_y),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_cpu.sv
//------------------------------------------------------------------------------
// tb_seq_cpu
//   Self-checking bench for seq_cpu (8-bit/4-reg instance plus a
//   16-bit/8-reg instance). A behavioural model predicts every result.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_cpu;

  localparam int W    = 8;
  localparam int MAXV = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        carry;
  logic        zero;

  logic        x_in_valid;
  logic        x_in_ready;
  logic [24:0] x_instr;
  logic        x_out_valid;
  logic        x_out_ready;
  logic [15:0] x_result;
  logic        x_carry;
  logic        x_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_cpu #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  seq_cpu #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .instruction(x_instr), .out_valid(x_out_valid), .out_ready(x_out_ready),
    .result(x_result), .carry(x_carry), .zero(x_zero)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int y;
    bit c;
    int rd;
    int due;
    bit seen;
  } exp_t;

  exp_t q[$];
  int   m_regs [4];
  int   cyc = 0;

  function automatic void model_op(input int op, input int a, input int b,
                                   input int fld, output int y, output bit c);
    int s;
    c = 0;
    case (op)
      0: y = fld;
      1, 6: begin
        s = a + ((op == 6) ? 1 : b);
        c = (s > MAXV);
        y = s % (MAXV + 1);
`ifdef SEQ_CPU_SAT_EN
        if (c) y = MAXV;
`endif
      end
      2, 7: begin
        s = (op == 7) ? 1 : b;
        c = (a < s);
        y = (a - s + MAXV + 1) % (MAXV + 1);
`ifdef SEQ_CPU_SAT_EN
        if (c) y = 0;
`endif
      end
      3: y = a & b;
      4: y = a | b;
      default: y = MAXV - a;
    endcase
  endfunction

  // Compare process: checks outputs on every cycle they are meaningful.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 8'h00 ||
            carry !== 1'b0 || zero !== 1'b0) begin
          bad++;
          $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h c=%b z=%b want 0/0/00/0/0",
                   in_ready, out_valid, result, carry, zero);
        end
        q.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
      end else begin
        if (q.size() > 0 && !q[0].seen && cyc > q[0].due) begin
          total++; bad++;
          $display("FAIL latency_timeout: result not valid by cycle %0d (now %0d)", q[0].due, cyc);
          void'(q.pop_front());
        end
        if (out_valid) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious_valid: out_valid=1 res=%h with no instruction pending", result);
          end else begin
            if (!q[0].seen) begin
              q[0].seen = 1;
              m_regs[q[0].rd] = q[0].y;
              total++;
              if (cyc != q[0].due) begin
                bad++;
                $display("FAIL latency: valid at cycle %0d, required %0d", cyc, q[0].due);
              end
            end
            if (result !== 8'(q[0].y) || carry !== q[0].c ||
                zero !== (q[0].y == 0) || in_ready !== 1'b0) begin
              bad++;
              $display("FAIL result_model: got res=%h c=%b z=%b rdy=%b want res=%h c=%b z=%b rdy=0",
                       result, carry, zero, in_ready, 8'(q[0].y), q[0].c, (q[0].y == 0));
            end
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          exp_t e;
          int op, rs1v, fld;
          op   = int'(instruction[14:12]);
          rs1v = int'(instruction[9:8]);
          fld  = int'(instruction[7:0]);
          model_op(op, m_regs[rs1v], m_regs[fld % 4], fld, e.y, e.c);
          e.rd   = int'(instruction[11:10]);
          e.due  = cyc + 3;
          e.seen = 0;
          q.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [7:0] fld, input bit rnd);
    int n;
    in_valid    = 1'b1;
    instruction = {op, rd, rs1, fld};
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (n == 60) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready never rose for op=%0d", op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Waits for out_valid (expected on the 3rd sample) and checks literals.
  task automatic wait_lit(input string name, input logic [7:0] er,
                          input logic ec, input logic ez);
    int n;
    for (n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    total++;
    if (!out_valid || n != 3 || result !== er || carry !== ec || zero !== ez) begin
      bad++;
      $display("FAIL %s: got vld=%b lat=%0d res=%h c=%b z=%b want vld=1 lat=3 res=%h c=%b z=%b",
               name, out_valid, n, result, carry, zero, er, ec, ez);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_lit(input string name, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [7:0] fld,
                         input logic [7:0] er, input logic ec, input logic ez);
    send(op, rd, rs1, fld, 0);
    wait_lit(name, er, ec, ez);
  endtask

  task automatic run16(input string name, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [15:0] fld,
                       input logic [15:0] er, input logic ec, input logic ez);
    int n;
    x_in_valid = 1'b1;
    x_instr    = {op, rd, rs1, fld};
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (x_in_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    for (n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (x_out_valid) break;
    end
    total++;
    if (!x_out_valid || x_result !== er || x_carry !== ec || x_zero !== ez) begin
      bad++;
      $display("FAIL %s: got vld=%b res=%h c=%b z=%b want vld=1 res=%h c=%b z=%b",
               name, x_out_valid, x_result, x_carry, x_zero, er, ec, ez);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_release;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: in_ready=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_edge: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b1;
    x_in_valid = 1'b0; x_instr = '0; x_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    check_release();

    // Basic ALU function
    run_lit("ldi_r1",  3'd0, 2'd1, 2'd0, 8'h23, 8'h23, 1'b0, 1'b0);
    run_lit("ldi_r2",  3'd0, 2'd2, 2'd0, 8'h14, 8'h14, 1'b0, 1'b0);
    run_lit("add",     3'd1, 2'd3, 2'd1, 8'h02, 8'h37, 1'b0, 1'b0);
    run_lit("sub",     3'd2, 2'd3, 2'd1, 8'h02, 8'h0F, 1'b0, 1'b0);
    run_lit("and",     3'd3, 2'd3, 2'd1, 8'h02, 8'h00, 1'b0, 1'b1);
    run_lit("or",      3'd4, 2'd3, 2'd1, 8'hF2, 8'h37, 1'b0, 1'b0);
    run_lit("not",     3'd5, 2'd3, 2'd1, 8'h00, 8'hDC, 1'b0, 1'b0);
    run_lit("inc",     3'd6, 2'd3, 2'd1, 8'h00, 8'h24, 1'b0, 1'b0);
    run_lit("dec",     3'd7, 2'd3, 2'd1, 8'h00, 8'h22, 1'b0, 1'b0);

    // Boundaries
    run_lit("ldi_ff",  3'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
`ifdef SEQ_CPU_SAT_EN
    run_lit("inc_ovf", 3'd6, 2'd0, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b0);
`else
    run_lit("inc_ovf", 3'd6, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
`endif
    run_lit("ldi_00",  3'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
`ifdef SEQ_CPU_SAT_EN
    run_lit("dec_unf", 3'd7, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
`else
    run_lit("dec_unf", 3'd7, 2'd0, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b0);
`endif

    // Backpressure: hold DONE for 5 cycles with a competing in_valid
    out_ready = 1'b0;
    send(3'd1, 2'd3, 2'd1, 8'h02, 0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    in_valid    = 1'b1;
    instruction = {3'd0, 2'd2, 2'd0, 8'h99};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h37) begin
        bad++;
        $display("FAIL backpressure_hold: vld=%b rdy=%b res=%h want 1/0/37",
                 out_valid, in_ready, result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_seen_cycle: vld=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_pop: vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_lit("held_ldi", 8'h99, 1'b0, 1'b0);

    // Async reset in EXEC
    run_lit("ldi_r3",  3'd0, 2'd3, 2'd0, 8'h77, 8'h77, 1'b0, 1'b0);
    send(3'd0, 2'd3, 2'd0, 8'h55, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 8'h00 ||
        carry !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: vld=%b rdy=%b res=%h c=%b z=%b want all 0",
               out_valid, in_ready, result, carry, zero);
    end
    repeat (2) @(posedge clk);
    check_release();
    run_lit("readback", 3'd4, 2'd3, 2'd3, 8'h03, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1);
    end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, want 0", q.size());
    end

    // 16-bit / 8-register instance
    run16("w16_ldi", 3'd0, 3'd7, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
`ifdef SEQ_CPU_SAT_EN
    run16("w16_add", 3'd1, 3'd6, 3'd7, 16'h0007, 16'hFFFF, 1'b1, 1'b0);
`else
    run16("w16_add", 3'd1, 3'd6, 3'd7, 16'h0007, 16'hFFFE, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
